// File: rtl/btb_update_arbiter_pkg.sv
// Shared types and constants for the BTB write-port arbiter and its retire-update FIFO.
package btb_update_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int BTB_ENTRIES = 32;
    localparam int BTB_IDX_LSB = 5;
    localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
    localparam int BTB_QDEPTH  = 4;

    typedef enum logic [1:0] {
        BTB_WR_INIT    = 2'd0,
        BTB_WR_RECOVER = 2'd1,
        BTB_WR_RETIRE  = 2'd2
    } btb_wr_kind_e;

    typedef struct packed {
        logic [BTB_IDX_W-1:0] index;
        logic                 taken;
        logic [XLEN-1:0]      target;
    } btb_upd_entry_t;

    function automatic logic [BTB_IDX_W-1:0] btb_pc_index(input logic [XLEN-1:0] pc,
                                                          input int lsb);
        logic [XLEN-1:0] shifted;
        shifted = pc >> lsb;
        return shifted[BTB_IDX_W-1:0];
    endfunction

    function automatic logic [1:0] btb_lane_count(input logic [1:0] lanes);
        return {1'b0, lanes[0]} + {1'b0, lanes[1]};
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Retire-update FIFO: up to two pushes and one pop per cycle, reports free slots
// including the slot released by this cycle's pop.
module btb_upd_fifo
    import btb_update_arbiter_pkg::*;
#(
    parameter int  Q_DEPTH = BTB_QDEPTH,
    localparam int PW      = $clog2(Q_DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [1:0]     push_n,
    input  btb_upd_entry_t push_data0,
    input  btb_upd_entry_t push_data1,
    input  logic           pop,
    output btb_upd_entry_t head,
    output logic           empty,
    output logic [CW-1:0]  count,
    output logic [CW-1:0]  free_slots
);

    logic [PW-1:0]  rd_ptr_r;
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  wr_ptr_p1_s;
    logic [CW-1:0]  count_r;
    logic           pop_s;
    btb_upd_entry_t mem_r [Q_DEPTH];

    assign empty       = (count_r == CW'(0));
    assign pop_s       = pop & ~empty;
    assign wr_ptr_p1_s = wr_ptr_r + PW'(1);
    assign head        = mem_r[rd_ptr_r];
    assign count       = count_r;
    assign free_slots  = CW'(Q_DEPTH) - count_r + CW'(pop_s);

    // Storage, pointers and occupancy; the second push lands one slot after the first.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < Q_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_n != 2'd0) begin
                mem_r[wr_ptr_r] <= push_data0;
            end
            if (push_n == 2'd2) begin
                mem_r[wr_ptr_p1_s] <= push_data1;
            end
            wr_ptr_r <= wr_ptr_r + PW'(push_n);
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            count_r <= count_r + CW'(push_n) - CW'(pop_s);
        end
    end

endmodule

// File: rtl/btb_update_arbiter.sv
// Single BTB write port: initialisation sweep after reset, then recovery writes with
// absolute priority over buffered retire updates.
module btb_update_arbiter
    import btb_update_arbiter_pkg::*;
#(
    parameter int  BTB_SIZE = BTB_ENTRIES,
    parameter int  IDX_LSB  = BTB_IDX_LSB,
    parameter int  Q_DEPTH  = BTB_QDEPTH,
    localparam int IDX_W    = $clog2(BTB_SIZE),
    localparam int CW       = $clog2(Q_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           branch_retire_i,
    input  logic [1:0][XLEN-1:0] retire_PC_i,
    input  logic [1:0]           retire_taken_i,
    input  logic [1:0][XLEN-1:0] retire_target_i,
    input  logic                 branch_recover_i,
    input  logic [XLEN-1:0]      recover_branch_pc_i,
    input  logic [XLEN-1:0]      recover_addr_i,
    output logic                 btb_wr_en_o,
    output logic [IDX_W-1:0]     btb_wr_index_o,
    output logic [1:0]           btb_wr_kind_o,
    output logic                 btb_wr_taken_o,
    output logic [XLEN-1:0]      btb_wr_target_o,
    output logic                 init_busy_o,
    output logic [CW-1:0]        queue_count_o,
    output logic [15:0]          drop_count_o
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e         state_r, state_n;
    logic [IDX_W-1:0] init_idx_r, init_idx_n;
    logic [15:0]    drop_r, drop_n;

    logic           wr_en_s;
    btb_wr_kind_e   kind_s;
    logic [IDX_W-1:0] idx_s;
    logic           taken_s;
    logic [XLEN-1:0] target_s;
    logic           pop_s;
    logic [1:0]     push_n_s;
    logic [1:0]     lane_cnt_s;
    logic [1:0]     accept_s;
    logic [1:0]     drop_inc_s;
    logic [16:0]    drop_sum_s;
    btb_upd_entry_t lane0_s, lane1_s, push_d0_s, push_d1_s, head_s;
    logic           empty_s;
    logic [CW-1:0]  count_s;
    logic [CW-1:0]  free_s;

    btb_upd_fifo #(.Q_DEPTH(Q_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_n     (push_n_s),
        .push_data0 (push_d0_s),
        .push_data1 (push_d1_s),
        .pop        (pop_s),
        .head       (head_s),
        .empty      (empty_s),
        .count      (count_s),
        .free_slots (free_s)
    );

    // Next-state, write-port selection and enqueue/drop decisions.
    always_comb begin
        state_n    = state_r;
        init_idx_n = init_idx_r;
        wr_en_s    = 1'b0;
        kind_s     = BTB_WR_INIT;
        idx_s      = '0;
        taken_s    = 1'b0;
        target_s   = '0;
        pop_s      = 1'b0;
        push_n_s   = 2'd0;
        accept_s   = 2'd0;
        drop_inc_s = 2'd0;
        lane_cnt_s = btb_lane_count(branch_retire_i);
        lane0_s    = '{index:  btb_pc_index(retire_PC_i[0], IDX_LSB),
                       taken:  retire_taken_i[0],
                       target: retire_target_i[0]};
        lane1_s    = '{index:  btb_pc_index(retire_PC_i[1], IDX_LSB),
                       taken:  retire_taken_i[1],
                       target: retire_target_i[1]};
        // A lone lane-1 retire takes the first free slot.
        push_d0_s  = branch_retire_i[0] ? lane0_s : lane1_s;
        push_d1_s  = lane1_s;

        case (state_r)
            ST_INIT: begin
                wr_en_s    = 1'b1;
                kind_s     = BTB_WR_INIT;
                idx_s      = init_idx_r;
                init_idx_n = init_idx_r + IDX_W'(1);
                drop_inc_s = lane_cnt_s + {1'b0, branch_recover_i};
                if (init_idx_r == IDX_W'(BTB_SIZE - 1)) begin
                    state_n = ST_RUN;
                end else begin
                    state_n = ST_INIT;
                end
            end
            ST_RUN: begin
                if (branch_recover_i) begin
                    wr_en_s  = 1'b1;
                    kind_s   = BTB_WR_RECOVER;
                    idx_s    = btb_pc_index(recover_branch_pc_i, IDX_LSB);
                    target_s = recover_addr_i;
                end else if (!empty_s) begin
                    wr_en_s  = 1'b1;
                    kind_s   = BTB_WR_RETIRE;
                    idx_s    = head_s.index;
                    taken_s  = head_s.taken;
                    target_s = head_s.target;
                    pop_s    = 1'b1;
                end else begin
                    wr_en_s  = 1'b0;
                end
                if (free_s >= CW'(2)) begin
                    accept_s = lane_cnt_s;
                end else if (free_s == CW'(1)) begin
                    accept_s = (lane_cnt_s != 2'd0) ? 2'd1 : 2'd0;
                end else begin
                    accept_s = 2'd0;
                end
                push_n_s   = accept_s;
                drop_inc_s = lane_cnt_s - accept_s;
            end
            default: begin
                state_n = ST_INIT;
            end
        endcase

        if (reset) begin
            pop_s    = 1'b0;
            push_n_s = 2'd0;
        end else begin
            pop_s    = pop_s;
            push_n_s = push_n_s;
        end

        drop_sum_s = {1'b0, drop_r} + {15'd0, drop_inc_s};
        drop_n     = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end

    // FSM state, initialisation index and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_INIT;
            init_idx_r <= '0;
            drop_r     <= 16'd0;
        end else begin
            state_r    <= state_n;
            init_idx_r <= init_idx_n;
            drop_r     <= drop_n;
        end
    end

    assign btb_wr_en_o     = wr_en_s & ~reset;
    assign btb_wr_index_o  = idx_s;
    assign btb_wr_kind_o   = kind_s;
    assign btb_wr_taken_o  = taken_s;
    assign btb_wr_target_o = target_s;
    assign init_busy_o     = reset | (state_r == ST_INIT);
    assign queue_count_o   = reset ? CW'(0) : count_s;
    assign drop_count_o    = reset ? 16'd0 : drop_r;

endmodule

// File: tb/tb_btb_update_arbiter.sv
// Randomised scoreboard bench for btb_update_arbiter with a queue-based reference model.
module tb_btb_update_arbiter;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       branch_retire = 2'b00;
    logic [1:0][31:0] retire_pc = '0;
    logic [1:0]       retire_taken = 2'b00;
    logic [1:0][31:0] retire_target = '0;
    logic             branch_recover = 1'b0;
    logic [31:0]      recover_pc = '0;
    logic [31:0]      recover_addr = '0;
    logic             wr_en;
    logic [4:0]       wr_index;
    logic [1:0]       wr_kind;
    logic             wr_taken;
    logic [31:0]      wr_target;
    logic             init_busy;
    logic [2:0]       queue_count;
    logic [15:0]      drop_count;

    always #5 clk = ~clk;

    btb_update_arbiter dut (
        .clk                 (clk),
        .reset               (reset),
        .branch_retire_i     (branch_retire),
        .retire_PC_i         (retire_pc),
        .retire_taken_i      (retire_taken),
        .retire_target_i     (retire_target),
        .branch_recover_i    (branch_recover),
        .recover_branch_pc_i (recover_pc),
        .recover_addr_i      (recover_addr),
        .btb_wr_en_o         (wr_en),
        .btb_wr_index_o      (wr_index),
        .btb_wr_kind_o       (wr_kind),
        .btb_wr_taken_o      (wr_taken),
        .btb_wr_target_o     (wr_target),
        .init_busy_o         (init_busy),
        .queue_count_o       (queue_count),
        .drop_count_o        (drop_count)
    );

    typedef struct {
        logic        en;
        logic [1:0]  kind;
        logic [4:0]  idx;
        logic        taken;
        logic [31:0] target;
        logic        busy;
        logic [2:0]  qcnt;
        logic [15:0] drop;
    } exp_t;

    typedef struct {
        logic [4:0]  idx;
        logic        taken;
        logic [31:0] target;
    } ent_t;

    exp_t exp_q[$];
    ent_t m_q[$];
    bit   m_init = 1'b1;
    int   m_iidx = 0;
    int   m_drop = 0;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    function automatic logic [4:0] pc_idx(input logic [31:0] pc);
        return 5'((pc / 32) % 32);
    endfunction

    // One clock of stimulus; the model predicts this cycle's outputs, then advances.
    task automatic step(input bit rst, input bit [1:0] rv,
                        input logic [31:0] pc0, input logic [31:0] pc1,
                        input bit t0, input bit t1,
                        input logic [31:0] tg0, input logic [31:0] tg1,
                        input bit rec, input logic [31:0] rpc, input logic [31:0] raddr);
        exp_t e;
        ent_t ln [2];
        int   nd;
        @(posedge clk);
        #1;
        reset = rst; branch_retire = rv;
        retire_pc[0] = pc0; retire_pc[1] = pc1;
        retire_taken = {t1, t0};
        retire_target[0] = tg0; retire_target[1] = tg1;
        branch_recover = rec; recover_pc = rpc; recover_addr = raddr;

        e = '{en: 1'b0, kind: 2'd0, idx: 5'd0, taken: 1'b0, target: 32'd0,
              busy: 1'b1, qcnt: 3'd0, drop: 16'd0};
        nd = 0;
        if (rst) begin
            exp_q.push_back(e);
            m_init = 1'b1; m_iidx = 0; m_drop = 0;
            m_q.delete();
        end else begin
            e.busy = m_init;
            e.qcnt = 3'(m_q.size());
            e.drop = 16'(m_drop);
            if (m_init) begin
                e.en = 1'b1; e.kind = 2'd0; e.idx = 5'(m_iidx);
                nd = int'(rv[0]) + int'(rv[1]) + int'(rec);
                m_iidx++;
                if (m_iidx == 32) m_init = 1'b0;
            end else begin
                if (rec) begin
                    e.en = 1'b1; e.kind = 2'd1; e.idx = pc_idx(rpc); e.target = raddr;
                end else if (m_q.size() > 0) begin
                    ent_t h;
                    h = m_q.pop_front();
                    e.en = 1'b1; e.kind = 2'd2; e.idx = h.idx; e.taken = h.taken; e.target = h.target;
                end
                ln[0] = '{idx: pc_idx(pc0), taken: t0, target: tg0};
                ln[1] = '{idx: pc_idx(pc1), taken: t1, target: tg1};
                for (int l = 0; l < 2; l++) begin
                    if (rv[l]) begin
                        if (m_q.size() < 4) m_q.push_back(ln[l]);
                        else nd++;
                    end
                end
            end
            m_drop = (m_drop + nd > 65535) ? 65535 : m_drop + nd;
            exp_q.push_back(e);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares the DUT's write port and status against the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (wr_en !== e.en ||
                (e.en && (wr_kind !== e.kind || wr_index !== e.idx ||
                          wr_taken !== e.taken || wr_target !== e.target))) begin
                $display("FAIL write cyc=%0d got en=%b kind=%0d idx=%0d tk=%b tgt=%h exp en=%b kind=%0d idx=%0d tk=%b tgt=%h",
                         cyc, wr_en, wr_kind, wr_index, wr_taken, wr_target,
                         e.en, e.kind, e.idx, e.taken, e.target);
            end else begin
                passes++;
            end
            checks++;
            if (init_busy !== e.busy || queue_count !== e.qcnt || drop_count !== e.drop) begin
                $display("FAIL status cyc=%0d got busy=%b qcnt=%0d drop=%0d exp busy=%b qcnt=%0d drop=%0d",
                         cyc, init_busy, queue_count, drop_count, e.busy, e.qcnt, e.drop);
            end else begin
                passes++;
            end
        end
    end

    // Directed scenarios followed by randomised traffic with occasional resets.
    initial begin
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(34);
        step(0, 2'b11, 32'h20, 32'h40, 1, 0, 32'h100, 32'h200, 0, 0, 0);
        idle(3);
        step(0, 2'b11, 32'hA0, 32'hC0, 1, 1, 32'h300, 32'h400, 1, 32'h80, 32'h2000);
        step(0, 2'b11, 32'hE0, 32'h100, 0, 1, 32'h500, 32'h600, 1, 32'hA0, 32'h3000);
        step(0, 2'b11, 32'h120, 32'h140, 1, 1, 32'h700, 32'h800, 1, 32'h60, 32'h1000);
        idle(1);
        step(0, 2'b11, 32'h160, 32'h180, 0, 1, 32'h900, 32'hA00, 0, 0, 0);
        idle(2);
        step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        step(0, 2'b11, 32'h1A0, 32'h1C0, 1, 1, 32'h11, 32'h22, 1, 32'h1E0, 32'h33);
        idle(32);
        step(0, 2'b10, 32'h0, 32'h3E0, 0, 1, 32'h0, 32'hBEEF, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 399) == 0),
                 2'($urandom_range(0, 3)),
                 $urandom, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom,
                 ($urandom_range(0, 3) == 0), $urandom, $urandom);
        end
        idle(6);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain got %0d pending expectations, exp 0", exp_q.size());
        end else begin
            passes++;
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
